// File: rtl/stim_sweep_gen_if.sv
// Valid/ready stimulus bus between the sweep generator and its consumer.
// The master drives the vector and its valid flag; the slave returns ready.
interface stim_sweep_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] stim;
  logic             stim_valid;
  logic             stim_ready;

  modport master (output stim, output stim_valid, input stim_ready);
  modport slave  (input stim, input stim_valid, output stim_ready);
endinterface

// File: rtl/stim_sweep_gen.sv
// Clocked stimulus sequencer: sweeps first_val..last_val in step increments,
// presenting each vector over valid/ready with an optional dwell gap.
module stim_sweep_gen #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   first_val,
  input  logic [WIDTH-1:0]   last_val,
  input  logic [WIDTH-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  stim_sweep_gen_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic [WIDTH:0]     vec_count
);

  localparam int unsigned CNT_W = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     next_sum;
  logic               is_final;
  logic               handshake;

  // The extra sum bit catches carry-out, so a wrapped value never counts as in range.
  always_comb begin
    next_sum  = {1'b0, stim_q} + {1'b0, step_q};
    is_final  = (stim_q >= last_q) || (next_sum > {1'b0, last_q});
    handshake = (state_q == S_PRESENT) && bus.stim_ready;
  end

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    last_d      = last_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stim_d  = first_val;
          last_d  = last_val;
          step_d  = (step == '0) ? WIDTH'(1) : step;
          dwell_d = dwell;
          cnt_d   = '0;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (handshake) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          if (is_final) begin
            state_d = S_DONE;
          end else begin
            stim_d = next_sum[WIDTH-1:0];
            if (dwell_q != '0) begin
              dwell_cnt_d = dwell_q;
              state_d     = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        // Leaving when the counter reads 1 makes the gap exactly dwell cycles.
        if (abort) begin
          state_d = S_IDLE;
        end else if (dwell_cnt_q <= DWELL_W'(1)) begin
          dwell_cnt_d = '0;
          state_d     = S_PRESENT;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stim_q      <= '0;
      last_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      last_q      <= last_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      cnt_q       <= cnt_d;
      valid_q     <= (state_d == S_PRESENT);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.stim       = stim_q;
  assign bus.stim_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign vec_count      = cnt_q;

endmodule

// File: tb/tb_stim_sweep_gen.sv
// Directed bench for stim_sweep_gen: a table of sweep configurations with
// hand-computed vectors, plus sequences for backpressure, abort and reset.
module tb_stim_sweep_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [W-1:0]       first;
    logic [W-1:0]       last;
    logic [W-1:0]       step;
    logic [DW-1:0]      dwell;
    logic [2:0]         n;
    logic [3:0][W-1:0]  v;
    logic               poke;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  first_val;
  logic [W-1:0]  last_val;
  logic [W-1:0]  step;
  logic [DW-1:0] dwell;
  logic          busy;
  logic          done;
  logic [W:0]    vec_count;

  int checks = 0;
  int errors = 0;

  stim_sweep_gen_if #(.WIDTH(W)) bus ();

  stim_sweep_gen #(.WIDTH(W), .DWELL_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .first_val (first_val),
    .last_val  (last_val),
    .step      (step),
    .dwell     (dwell),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] f, input logic [7:0] l, input logic [7:0] s,
                              input logic [3:0] d, input logic [2:0] n,
                              input logic [7:0] v0, input logic [7:0] v1,
                              input logic [7:0] v2, input logic [7:0] v3, input logic p);
    vec_t r;
    r.first = f; r.last = l; r.step = s; r.dwell = d; r.n = n;
    r.v[0] = v0; r.v[1] = v1; r.v[2] = v2; r.v[3] = v3;
    r.poke = p;
    return r;
  endfunction

  // Runs one sweep with ready held high and checks vectors, gaps and the done cycle.
  task automatic run_case(input vec_t c, input int idx);
    int  got = 0;
    int  gap = 0;
    bit  fin = 0;
    first_val = c.first; last_val = c.last; step = c.step; dwell = c.dwell;
    bus.stim_ready = 1'b1;
    start = 1'b1;
    tick();
    if (c.poke) begin
      first_val = 8'd99; last_val = 8'd200; step = 8'd50; dwell = 4'd0;
    end else begin
      start = 1'b0;
    end
    chk($sformatf("case%0d busy_on_launch", idx), 32'(busy), 32'd1);
    chk($sformatf("case%0d valid_on_launch", idx), 32'(bus.stim_valid), 32'd1);
    chk($sformatf("case%0d first_stim", idx), 32'(bus.stim), 32'(c.first));
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (bus.stim_valid === 1'b1) begin
        if (got >= int'(c.n)) chk($sformatf("case%0d vector_count", idx), 32'(got + 1), 32'(c.n));
        else chk($sformatf("case%0d vec%0d", idx, got), 32'(bus.stim), 32'(c.v[got]));
        if (got > 0) chk($sformatf("case%0d gap%0d", idx, got), 32'(gap), 32'(c.dwell));
        got++;
        gap = 0;
      end else if (done === 1'b1) begin
        chk($sformatf("case%0d accepted", idx), 32'(got), 32'(c.n));
        chk($sformatf("case%0d vec_count", idx), 32'(vec_count), 32'(c.n));
        chk($sformatf("case%0d busy_in_done", idx), 32'(busy), 32'd1);
        fin = 1;
      end else begin
        gap++;
      end
      if (!fin) tick();
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL case%0d timeout: done not seen, got %0d vectors", idx, got);
    end
    tick();
    chk($sformatf("case%0d done_pulse_width", idx), 32'(done), 32'd0);
    chk($sformatf("case%0d busy_after_done", idx), 32'(busy), 32'd0);
    start = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(8'd0,   8'd3,   8'd1,   4'd0, 3'd4, 8'd0,   8'd1,   8'd2,  8'd3,  1'b0);
    tbl[1] = mk(8'd250, 8'd255, 8'd4,   4'd0, 3'd2, 8'd250, 8'd254, 8'd0,  8'd0,  1'b0);
    tbl[2] = mk(8'd252, 8'd255, 8'd8,   4'd0, 3'd1, 8'd252, 8'd0,   8'd0,  8'd0,  1'b0);
    tbl[3] = mk(8'd5,   8'd7,   8'd0,   4'd0, 3'd3, 8'd5,   8'd6,   8'd7,  8'd0,  1'b0);
    tbl[4] = mk(8'd9,   8'd4,   8'd1,   4'd0, 3'd1, 8'd9,   8'd0,   8'd0,  8'd0,  1'b0);
    tbl[5] = mk(8'd0,   8'd2,   8'd1,   4'd2, 3'd3, 8'd0,   8'd1,   8'd2,  8'd0,  1'b0);
    tbl[6] = mk(8'd10,  8'd40,  8'd10,  4'd1, 3'd4, 8'd10,  8'd20,  8'd30, 8'd40, 1'b0);
    tbl[7] = mk(8'd0,   8'd255, 8'd255, 4'd0, 3'd2, 8'd0,   8'd255, 8'd0,  8'd0,  1'b0);
    tbl[8] = mk(8'd0,   8'd3,   8'd1,   4'd1, 3'd4, 8'd0,   8'd1,   8'd2,  8'd3,  1'b1);

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    first_val = '0; last_val = '0; step = '0; dwell = '0;
    bus.stim_ready = 1'b0;
    tick();
    tick();
    chk("reset stim", 32'(bus.stim), 32'd0);
    chk("reset valid", 32'(bus.stim_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset vec_count", 32'(vec_count), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_case(tbl[i], i);
      tick();
    end

    // Backpressure: vector 1 must stay put while ready is low.
    first_val = 8'd0; last_val = 8'd3; step = 8'd1; dwell = 4'd0;
    bus.stim_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.stim_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp stim c%0d", i), 32'(bus.stim), 32'd1);
      chk($sformatf("bp valid c%0d", i), 32'(bus.stim_valid), 32'd1);
      chk($sformatf("bp count c%0d", i), 32'(vec_count), 32'd1);
      tick();
    end
    bus.stim_ready = 1'b1;
    tick();
    chk("bp stim after release", 32'(bus.stim), 32'd2);
    chk("bp count after release", 32'(vec_count), 32'd2);
    wait_done("bp", 20);
    chk("bp final count", 32'(vec_count), 32'd4);
    tick();
    tick();

    // Abort after two accepted vectors, no handshake in the abort cycle.
    first_val = 8'd0; last_val = 8'd15; step = 8'd1; dwell = 4'd0;
    bus.stim_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    bus.stim_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort valid", 32'(bus.stim_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort count", 32'(vec_count), 32'd2);
    chk("abort stim", 32'(bus.stim), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort no_done c%0d", i), 32'(done), 32'd0);
    end
    first_val = 8'd7; last_val = 8'd8;
    bus.stim_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart stim", 32'(bus.stim), 32'd7);
    chk("restart count", 32'(vec_count), 32'd0);
    chk("restart valid", 32'(bus.stim_valid), 32'd1);
    wait_done("restart", 20);
    chk("restart final count", 32'(vec_count), 32'd2);
    tick();
    tick();

    // Abort coinciding with a handshake still counts that vector.
    first_val = 8'd0; last_val = 8'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_hs count", 32'(vec_count), 32'd1);
    chk("abort_hs stim", 32'(bus.stim), 32'd0);
    chk("abort_hs valid", 32'(bus.stim_valid), 32'd0);
    tick();

    // Reset while in HOLD.
    first_val = 8'd0; last_val = 8'd2; step = 8'd1; dwell = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("hold valid", 32'(bus.stim_valid), 32'd0);
    chk("hold busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold stim", 32'(bus.stim), 32'd0);
    chk("rst_hold valid", 32'(bus.stim_valid), 32'd0);
    chk("rst_hold busy", 32'(busy), 32'd0);
    chk("rst_hold done", 32'(done), 32'd0);
    chk("rst_hold count", 32'(vec_count), 32'd0);
    tick();
    chk("rst_hold stays idle", 32'(bus.stim_valid), 32'd0);

    // Reset together with start keeps the block idle.
    first_val = 8'd5; last_val = 8'd9; dwell = 4'd0;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start busy", 32'(busy), 32'd0);
    chk("rst_start valid", 32'(bus.stim_valid), 32'd0);
    chk("rst_start stim", 32'(bus.stim), 32'd0);
    tick();
    chk("rst_start still idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
